// File: rtl/tt_um_uart_tx.sv
// ---------------------------------------------------------------------------
// tt_um_uart_tx -- 8N1 UART transmitter in the Tiny Tapeout user-module shell.
//
// Frame layout: START(0), 8 data bits LSB first, optional PARITY (even),
// STOP(1). Each bit lasts CLKS_PER_BIT clock cycles.
//
// Optional feature macro:
//   UART_TX_PARITY_EN  -- when defined, an even-parity bit is inserted
//                         between the last data bit and the stop bit.
//
// Pin map:
//   ui_in[7:0]   byte to transmit (latched when a frame is accepted)
//   uio_in[0]    start request (level-sensitive, honoured only in IDLE, ena=1)
//   uo_out[0]    txd
//   uo_out[1]    busy
//   uo_out[2]    done (one-cycle pulse as the FSM returns to IDLE)
//   uio_out[7:1] frames-sent counter (wraps modulo 128)
//   uio_oe       constant 8'b1111_1110
// ---------------------------------------------------------------------------
module tt_um_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  // Bit timer counts 0 .. CLKS_PER_BIT-1 inside every serial bit.
  localparam int              TIMER_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TIMER_W-1:0] TIMER_MAX = TIMER_W'(CLKS_PER_BIT - 1);

  // FSM encoding.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [2:0]         state;
  logic [2:0]         state_next;
  logic [TIMER_W-1:0] bit_timer;
  logic [2:0]         bit_idx;
  logic [7:0]         shift_reg;
  logic               txd;
  logic               txd_next;
  logic               busy;
  logic               done;
  logic [6:0]         frame_cnt;
`ifdef UART_TX_PARITY_EN
  logic               parity_bit;
`endif

  // Decoded events
  logic start_req;
  logic accept;
  logic bit_end;
  logic last_data_bit;
  logic frame_end;

  // Only uio_in[0] is meaningful; the upper bits are deliberately ignored.
  logic unused_uio_bits;
  assign unused_uio_bits = &{1'b0, uio_in[7:1]};

  assign start_req     = uio_in[0];
  assign bit_end       = (bit_timer == TIMER_MAX);
  assign last_data_bit = (bit_idx == 3'd7);
  assign accept        = (state == IDLE) && ena && start_req;
  assign frame_end     = (state == STOP) && bit_end;

  // -------------------------------------------------------------------------
  // Next-state and next-txd decode
  // -------------------------------------------------------------------------
  // Transition on the final cycle of each bit; txd is precomputed so the
  // registered line changes exactly on the bit boundary.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    state_next = state;
    txd_next   = txd;
    case (state)
      IDLE: begin
        if (accept) begin
          state_next = START;
          txd_next   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          txd_next   = shift_reg[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (last_data_bit) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
            txd_next   = parity_bit;
`else
            state_next = STOP;
            txd_next   = 1'b1;
`endif
          end else begin
            txd_next = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_next = STOP;
          txd_next   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_next = IDLE;
          txd_next   = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        txd_next   = 1'b1;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequential state
  // -------------------------------------------------------------------------
  // FSM state register; reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of block order.
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bit timer: free-runs inside a bit, held at zero while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_timer <= '0;
    end else if ((state == IDLE) || bit_end) begin
      bit_timer <= '0;
    end else begin
      bit_timer <= bit_timer + 1'b1;
    end
  end

  // Data-bit index: advances at the end of each data bit, wraps 7 -> 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_idx <= 3'd0;
    end else if (accept) begin
      bit_idx <= 3'd0;
    end else if ((state == DATA) && bit_end) begin
      bit_idx <= bit_idx + 3'd1;
    end
  end

  // Shift register: loaded on acceptance so later ui_in changes are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shift_reg <= 8'h00;
    end else if (accept) begin
      shift_reg <= ui_in;
    end else if ((state == DATA) && bit_end) begin
      shift_reg <= {1'b0, shift_reg[7:1]};
    end
  end

`ifdef UART_TX_PARITY_EN
  // Even parity of the accepted byte, captured alongside the shift register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_bit <= 1'b0;
    end else if (accept) begin
      parity_bit <= ^ui_in;
    end
  end
`endif

  // Serial line register: idles high, and a reset forces it high at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      txd <= 1'b1;
    end else begin
      txd <= txd_next;
    end
  end

  // Status flags: busy mirrors "not IDLE", done pulses on the STOP exit edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= frame_end;
    end
  end

  // Frames-sent counter, wrapping modulo 128.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt <= 7'd0;
    end else if (frame_end) begin
      frame_cnt <= frame_cnt + 7'd1;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs (constant bits do not depend on reset)
  // -------------------------------------------------------------------------
  assign uo_out  = {5'b0_0000, done, busy, txd};
  assign uio_out = {frame_cnt, 1'b0};
  assign uio_oe  = 8'b1111_1110;

  // -------------------------------------------------------------------------
  // Structural invariants
  // -------------------------------------------------------------------------
  a_busy_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
    busy == (state != IDLE));

  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> !busy);

  a_idle_line_high: assert property (@(posedge clk) disable iff (!rst_n)
    !busy |-> txd);

endmodule

// File: doc/tt_um_uart_tx.md
TT_UM_UART_TX -- requirements
Module: tt_um_uart_tx

Interface
REQ-001 SHALL have parameter: CLKS_PER_BIT, 16, clock cycles per serial bit (legal range 2..65535).
REQ-002 SHALL have ports, one per line:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- ena  input  1  design selected; high enables new frames
- ui_in  input  8  byte to transmit
- uo_out  output  8  [0] txd, [1] busy, [2] done, [7:3] tied 0
- uio_in  input  8  [0] start request, [7:1] ignored
- uio_out  output  8  [0] tied 0, [7:1] frames-sent counter
- uio_oe  output  8  constant 8'b1111_1110
REQ-003 SHALL use one clock (clk); reset is synchronous and active-low (rst_n).

Function
REQ-004 SHALL implement the FSM IDLE -> START -> DATA -> STOP -> IDLE, plus PARITY between DATA and STOP when configured.
REQ-005 In IDLE, with ena=1 and uio_in[0]=1 at an edge, SHALL latch ui_in into the shift register and enter START on that edge.
- start is level-sensitive.
- Start is ignored outside IDLE.
- Start is ignored when ena=0.
REQ-006 txd SHALL be driven from a register, with the following levels:
- IDLE: 1
- START: 0
- DATA: 8 bits, LSB first
- STOP: 1
REQ-007 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a bit-timer of width $clog2(CLKS_PER_BIT).
REQ-008 A 3-bit index SHALL count data bits; DATA exits after index 7 completes.
REQ-009 busy SHALL be 1 in every state except IDLE: high from the cycle after the accepting edge through the last STOP cycle.
REQ-010 At the final edge of STOP, the FSM SHALL return to IDLE, and on that edge:
- done SHALL assert for exactly one cycle.
- The counter uio_out[7:1] SHALL increment modulo 128.
REQ-011 A start request present in the done cycle SHALL be accepted, giving a 1-cycle idle gap between back-to-back frames.
REQ-012 Changes on ui_in after acceptance SHALL NOT affect the frame in flight.
REQ-013 ena falling mid-frame SHALL NOT abort the frame; it completes normally.
REQ-014 Frame length SHALL be 10*CLKS_PER_BIT cycles (11*CLKS_PER_BIT with parity).
REQ-015 uio_oe, uo_out[7:3] and uio_out[0] SHALL be constants, independent of reset.

Reset
REQ-016 On any clk edge with rst_n=0, the block SHALL reset to:
- state IDLE
- txd=1, busy=0, done=0
- counter=0, bit-timer=0, index=0
- shift register=0
REQ-017 Reset mid-frame SHALL abort the frame: txd=1 from the cycle after the reset edge, with no done pulse.
REQ-018 A start request held during reset SHALL be accepted at the first edge with rst_n=1.

Configuration
REQ-019 With macro UART_TX_PARITY_EN defined, the PARITY state SHALL follow DATA for CLKS_PER_BIT cycles, driving even parity (XOR of the latched byte).
REQ-020 Without UART_TX_PARITY_EN, PARITY state logic SHALL be absent and DATA SHALL go directly to STOP.

Verification (CLKS_PER_BIT=4)
REQ-021 Send 0xA5 with no macro:
- txd = 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
- busy high 40 cycles.
- done is 1 cycle immediately after.
- counter=1.
REQ-022 Send 0xA5 with UART_TX_PARITY_EN:
- parity bit 0 inserted before stop.
- busy high 44 cycles.
- Send 0x01: parity bit 1.
REQ-023 Hold start=1 with ui_in=0x3C then 0xC3 changed mid-frame:
- First frame carries 0x3C.
- Second frame starts 1 cycle after done and carries 0xC3.
- counter=2.
REQ-024 ena=0 with start=1 for 50 cycles:
- txd stays 1, busy 0, counter 0.
- Raising ena starts a frame on the next edge.
REQ-025 Assert rst_n=0 for 1 cycle during bit 3 of DATA:
- txd=1, busy=0 next cycle.
- No done pulse; counter unchanged at 0.
REQ-026 Send 128 frames: counter wraps 127 -> 0; uio_oe reads 0xFE throughout.
